// File: rtl/e_mdu_if.sv
// Execute-stage multiply/divide unit bus.
// The master is the E-stage driver: it sends the flush (req), the op code and
// the forwarded operands. The slave is e_mdu: it returns busy and the
// HI/LO read data.
//   req       master->slave  flush of the E-stage instruction this cycle
//   md_op     master->slave  0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   rs_val    master->slave  rs operand
//   rt_val    master->slave  rt operand
//   busy      slave->master  op accepted this cycle or still in flight
//   md_rdata  slave->master  HI for mfhi, LO for mflo, else 0
interface e_mdu_if;
    logic        req;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] md_rdata;

    modport master (output req, md_op, rs_val, rt_val, input busy, md_rdata);
    modport slave  (input req, md_op, rs_val, rt_val, output busy, md_rdata);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit.
// Owns HI/LO. mult/multu/div/divu are computed in the accept cycle and parked
// in a pending register; the unit then stays busy for a fixed number of cycles
// before the pending value is committed to HI/LO. mthi/mtlo write in a single
// cycle, mfhi/mflo are combinational reads.
// Ports:
//   clk    clock, rising-edge
//   reset  synchronous active-high reset
//   bus    e_mdu_if slave modport (req, md_op, rs_val, rt_val -> busy, md_rdata)
//
// state | meaning
// IDLE  | cnt == 0, new md ops may be accepted, mthi/mtlo allowed
// RUN   | cnt != 0, counting down to the HI/LO commit
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi;
    logic [31:0]    lo;
    logic [63:0]    pend;
    logic           pend_valid;

    logic           busy_reg;
    logic           is_mult;
    logic           is_div;
    logic           accept;

    logic [63:0]    mul_a;
    logic [63:0]    mul_b;
    logic [63:0]    prod;

    logic           a_neg;
    logic           b_neg;
    logic [31:0]    a_mag;
    logic [31:0]    b_mag;
    logic [31:0]    b_safe;
    logic [31:0]    q_mag;
    logic [31:0]    r_mag;
    logic [31:0]    quot;
    logic [31:0]    rem;

    assign busy_reg = (cnt != '0);
    assign is_mult  = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
    assign is_div   = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
    assign accept   = (is_mult || is_div) && !bus.req && !busy_reg;
    assign bus.busy = accept || busy_reg;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
    // correct for both signed and unsigned operands.
    always_comb begin
        mul_a = {32'b0, bus.rs_val};
        mul_b = {32'b0, bus.rt_val};
        if (bus.md_op == OP_MULT) begin
            mul_a = {{32{bus.rs_val[31]}}, bus.rs_val};
            mul_b = {{32{bus.rt_val[31]}}, bus.rt_val};
        end
        prod = mul_a * mul_b;
    end

    // Signed division is done on magnitudes so that 0x80000000 / -1 needs no
    // special case (magnitude 0x80000000 / 1, no negation). A zero divisor is
    // replaced by 1 only to keep the divider defined; its result is discarded.
    always_comb begin
        a_neg  = (bus.md_op == OP_DIV) && bus.rs_val[31];
        b_neg  = (bus.md_op == OP_DIV) && bus.rt_val[31];
        a_mag  = a_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
        b_mag  = b_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
        b_safe = (bus.rt_val == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        bus.md_rdata = 32'd0;
        case (bus.md_op)
            OP_MFHI: bus.md_rdata = hi;
            OP_MFLO: bus.md_rdata = lo;
            default: bus.md_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            pend       <= 64'd0;
            pend_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        if (is_mult) begin
                            pend       <= prod;
                            pend_valid <= 1'b1;
                            cnt        <= CW'(MULT_CYCLES);
                        end else begin
                            pend       <= {rem, quot};
                            pend_valid <= (bus.rt_val != 32'd0);
                            cnt        <= CW'(DIV_CYCLES);
                        end
                    end else if (!bus.req && bus.md_op == OP_MTHI) begin
                        hi <= bus.rs_val;
                    end else if (!bus.req && bus.md_op == OP_MTLO) begin
                        lo <= bus.rs_val;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        if (pend_valid) begin
                            hi <= pend[63:32];
                            lo <= pend[31:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
